// File: rtl/uart_pkg.sv
// Shared UART definitions: serialiser state encoding, frame shape and baud divider helper.
package uart_pkg;

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } uart_state_e;

   localparam int DATA_BITS = 8;
   localparam int STOP_BITS = 1;

   // Rounds to the nearest whole number of clk cycles per bit.
   function automatic int calc_div(input int clk_hz, input int baud);
      return (clk_hz + baud / 2) / baud;
   endfunction

endpackage

// File: rtl/byte_fifo.sv
// Synchronous FIFO with registered full flag and occupancy count; shared by UART TX and RX paths.
module byte_fifo #(
   parameter int DEPTH = 16,
   parameter int WIDTH = 8
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en_i,
   input  logic [WIDTH-1:0]         wr_data_i,
   input  logic                     rd_en_i,
   output logic [WIDTH-1:0]         rd_data_o,
   output logic                     full_o,
   output logic                     empty_o,
   output logic [$clog2(DEPTH):0]   count_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]    count_q, count_d;
   logic             full_q;
   logic             wr, rd;

   // Writes while full are dropped; reads while empty are ignored.
   assign wr = wr_en_i & ~full_q;
   assign rd = rd_en_i & ~empty_o;

   always_comb begin
      count_d = count_q;
      unique case ({wr, rd})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rstn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         full_q   <= 1'b0;
      end else begin
         if (wr) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (rd) rd_ptr_q <= rd_ptr_q + 1'b1;
         count_q <= count_d;
         full_q  <= (count_d == CW'(DEPTH));
      end
   end

   // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
   always_ff @(posedge clk) begin
      if (wr) mem_q[wr_ptr_q] <= wr_data_i;
   end

   assign rd_data_o = mem_q[rd_ptr_q];
   assign full_o    = full_q;
   assign empty_o   = (count_q == '0);
   assign count_o   = count_q;

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter: byte FIFO feeding an LSB-first serialiser with back-to-back frames.
module uart_tx_buffered
   import uart_pkg::*;
#(
   parameter int CLK_HZ     = 12000000,
   parameter int BAUD       = 115200,
   parameter int DIV        = calc_div(CLK_HZ, BAUD),
   parameter int FIFO_DEPTH = 16
) (
   input  logic                          clk,
   input  logic                          rstn,
   input  logic                          tx_start_i,
   input  logic [7:0]                    tx_data_i,
   output logic                          tx_ready_o,
   output logic                          tx_o,
   output logic                          busy_o,
   output logic                          done_o,
   output logic [$clog2(FIFO_DEPTH):0]   level_o
);

   localparam int BW  = $clog2(DIV);
   localparam int CTW = $clog2(DATA_BITS);

   uart_state_e     state_q, state_d;
   logic [BW-1:0]   baud_q, baud_d;
   logic [CTW-1:0]  bit_q, bit_d;
   logic [7:0]      shift_q, shift_d;
   logic            tx_q, tx_d;
   logic            done_q, done_d;
   logic            busy_q, busy_d;

   logic            pop;
   logic            full, empty;
   logic [7:0]      fifo_data;
   logic            term;

   byte_fifo #(
      .DEPTH (FIFO_DEPTH),
      .WIDTH (8)
   ) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .wr_en_i   (tx_start_i),
      .wr_data_i (tx_data_i),
      .rd_en_i   (pop),
      .rd_data_o (fifo_data),
      .full_o    (full),
      .empty_o   (empty),
      .count_o   (level_o)
   );

   assign term = (baud_q == BW'(DIV - 1));

   // NOTE: every output of this block gets a default first so no path can infer a latch.
   always_comb begin
      state_d = state_q;
      bit_d   = bit_q;
      shift_d = shift_q;
      pop     = 1'b0;
      done_d  = 1'b0;
      baud_d  = (state_q == IDLE || term) ? '0 : baud_q + 1'b1;

      unique case (state_q)
         IDLE: begin
            if (!empty) begin
               pop     = 1'b1;
               shift_d = fifo_data;
               bit_d   = '0;
               state_d = START;
            end
         end
         START: begin
            if (term) state_d = DATA;
         end
         DATA: begin
            if (term) begin
               shift_d = {1'b0, shift_q[7:1]};
               bit_d   = bit_q + 1'b1;
               if (bit_q == CTW'(DATA_BITS - 1)) begin
                  bit_d   = '0;
                  state_d = STOP;
               end
            end
         end
         STOP: begin
            if (term) begin
               if (bit_q == CTW'(STOP_BITS - 1)) begin
                  done_d = 1'b1;
                  bit_d  = '0;
                  // Chain straight into the next start bit when more bytes are queued.
                  if (!empty) begin
                     pop     = 1'b1;
                     shift_d = fifo_data;
                     state_d = START;
                  end else begin
                     state_d = IDLE;
                  end
               end else begin
                  bit_d = bit_q + 1'b1;
               end
            end
         end
      endcase

      unique case (state_q)
         START:   tx_d = 1'b0;
         DATA:    tx_d = shift_q[0];
         default: tx_d = 1'b1;
      endcase

      busy_d = !empty || (state_q != IDLE);
   end

   // NOTE: sequential state uses non-blocking assignments only, so all registers update together.
   always_ff @(posedge clk) begin
      if (!rstn) begin
         state_q <= IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         shift_q <= '0;
         tx_q    <= 1'b1;
         done_q  <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         baud_q  <= baud_d;
         bit_q   <= bit_d;
         shift_q <= shift_d;
         tx_q    <= tx_d;
         done_q  <= done_d;
         busy_q  <= busy_d;
      end
   end

   assign tx_ready_o = ~full;
   assign tx_o       = tx_q;
   assign done_o     = done_q;
   assign busy_o     = busy_q;

endmodule
